// File: rtl/sprite_renderer_scaled.sv
// Draws one SPRITE_W x SPRITE_H 1bpp sprite per frame from a byte-wide ROM, with H/V mirroring and
// integer horizontal scaling. Define SPRITE_COLLISION_EN to add the playfield/collision ports.
module sprite_renderer_scaled #(
    parameter  int SPRITE_W    = 16,
    parameter  int SPRITE_H    = 16,
    parameter  int XSCALE_LOG2 = 0,
    localparam int NB          = SPRITE_W / 8,
    localparam int ROM_AW      = $clog2(SPRITE_H * NB)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vstart,
    input  logic              load,
    input  logic              hstart,
    input  logic              hmirror,
    input  logic              vmirror,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_bits,
    output logic              gfx,
    output logic              busy
`ifdef SPRITE_COLLISION_EN
    ,
    input  logic              playfield,
    output logic              collision
`endif
);

    // state       | meaning
    // WAIT_VSTART | idle between sprites, mirror bits latched on vstart
    // WAIT_LOAD   | waiting for the fetch window of the next row
    // SETUP       | present ROM address of the current row byte
    // CAPTURE     | store returned byte into the line buffer
    // WAIT_HSTART | row fetched, waiting for the sprite's left edge
    // DRAW        | shifting pixels out, each repeated 2**XSCALE_LOG2 clocks
    typedef enum logic [2:0] {
        WAIT_VSTART,
        WAIT_LOAD,
        SETUP,
        CAPTURE,
        WAIT_HSTART,
        DRAW
    } state_t;

    localparam int XW = $clog2(SPRITE_W);
    localparam int YW = $clog2(SPRITE_H);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int SW = (XSCALE_LOG2 > 0) ? XSCALE_LOG2 : 1;

    localparam logic [XW-1:0] XLAST   = XW'(SPRITE_W - 1);
    localparam logic [YW-1:0] YLAST   = YW'(SPRITE_H - 1);
    localparam logic [BW-1:0] BLAST   = BW'(NB - 1);
    localparam logic [SW-1:0] SUB_MAX = SW'((1 << XSCALE_LOG2) - 1);

    state_t              state;
    logic [SPRITE_W-1:0] linebuf;
    logic [XW-1:0]       xcount;
    logic [YW-1:0]       ycount;
    logic [BW-1:0]       bytecnt;
    logic [SW-1:0]       subcnt;
    logic                hm_q;
    logic                vm_q;

    logic [YW-1:0]       row;
    logic [XW-1:0]       pix_idx;
    logic [ROM_AW-1:0]   fetch_addr;

    assign row        = vm_q ? (YLAST - ycount) : ycount;
    assign pix_idx    = hm_q ? (XLAST - xcount) : xcount;
    assign fetch_addr = ROM_AW'(row) * ROM_AW'(NB) + ROM_AW'(bytecnt);
    assign busy       = (state != WAIT_VSTART);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_VSTART;
            gfx      <= 1'b0;
            rom_addr <= '0;
            linebuf  <= '0;
            xcount   <= '0;
            ycount   <= '0;
            bytecnt  <= '0;
            subcnt   <= '0;
            hm_q     <= 1'b0;
            vm_q     <= 1'b0;
        end else begin
            gfx <= 1'b0;
            case (state)
                WAIT_VSTART: begin
                    ycount <= '0;
                    if (vstart) begin
                        hm_q  <= hmirror;
                        vm_q  <= vmirror;
                        state <= WAIT_LOAD;
                    end
                end
                WAIT_LOAD: begin
                    xcount  <= '0;
                    bytecnt <= '0;
                    subcnt  <= '0;
                    if (load) state <= SETUP;
                end
                SETUP: begin
                    rom_addr <= fetch_addr;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    linebuf[8*bytecnt +: 8] <= rom_bits;
                    if (bytecnt == BLAST) begin
                        state <= WAIT_HSTART;
                    end else begin
                        bytecnt <= bytecnt + BW'(1);
                        state   <= SETUP;
                    end
                end
                WAIT_HSTART: begin
                    if (hstart) state <= DRAW;
                end
                DRAW: begin
                    gfx <= linebuf[pix_idx];
                    if (subcnt == SUB_MAX) begin
                        subcnt <= '0;
                        if (xcount == XLAST) begin
                            xcount <= '0;
                            if (ycount == YLAST) begin
                                ycount <= '0;
                                state  <= WAIT_VSTART;
                            end else begin
                                ycount <= ycount + YW'(1);
                                state  <= WAIT_LOAD;
                            end
                        end else begin
                            xcount <= xcount + XW'(1);
                        end
                    end else begin
                        subcnt <= subcnt + SW'(1);
                    end
                end
                default: state <= WAIT_VSTART;
            endcase
        end
    end

`ifdef SPRITE_COLLISION_EN
    // Clear on an accepted vstart takes priority over a same-clock hit.
    always_ff @(posedge clk) begin
        if (reset)
            collision <= 1'b0;
        else if (state == WAIT_VSTART && vstart)
            collision <= 1'b0;
        else if (gfx && playfield)
            collision <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sprite_renderer_scaled.sv
// Scoreboard bench for sprite_renderer_scaled: three instances (16 wide, 16 wide x2 scale, 32 wide)
// share control inputs; each scenario observes one of them against a reference pixel model.
module tb_sprite_renderer_scaled;
    localparam int H = 16;

    logic clk = 1'b0;
    logic reset, vstart, load, hstart, hmirror, vmirror, playfield;
    always #5 clk = ~clk;

    logic [7:0] rom16 [32];
    logic [7:0] rom32 [64];

    logic [4:0] addr_a, addr_b;
    logic [5:0] addr_c;
    logic [7:0] bits_a, bits_b, bits_c;
    logic gfx_a, gfx_b, gfx_c, busy_a, busy_b, busy_c;
    logic coll_a, coll_b, coll_c;

    assign bits_a = rom16[addr_a];
    assign bits_b = rom16[addr_b];
    assign bits_c = rom32[addr_c];

    sprite_renderer_scaled #(.SPRITE_W(16), .SPRITE_H(16), .XSCALE_LOG2(0)) dut_a (
        .clk(clk), .reset(reset), .vstart(vstart), .load(load), .hstart(hstart),
        .hmirror(hmirror), .vmirror(vmirror), .rom_addr(addr_a), .rom_bits(bits_a),
        .gfx(gfx_a), .busy(busy_a)
`ifdef SPRITE_COLLISION_EN
        , .playfield(playfield), .collision(coll_a)
`endif
    );

    sprite_renderer_scaled #(.SPRITE_W(16), .SPRITE_H(16), .XSCALE_LOG2(1)) dut_b (
        .clk(clk), .reset(reset), .vstart(vstart), .load(load), .hstart(hstart),
        .hmirror(hmirror), .vmirror(vmirror), .rom_addr(addr_b), .rom_bits(bits_b),
        .gfx(gfx_b), .busy(busy_b)
`ifdef SPRITE_COLLISION_EN
        , .playfield(1'b0), .collision(coll_b)
`endif
    );

    sprite_renderer_scaled #(.SPRITE_W(32), .SPRITE_H(16), .XSCALE_LOG2(0)) dut_c (
        .clk(clk), .reset(reset), .vstart(vstart), .load(load), .hstart(hstart),
        .hmirror(hmirror), .vmirror(vmirror), .rom_addr(addr_c), .rom_bits(bits_c),
        .gfx(gfx_c), .busy(busy_c)
`ifdef SPRITE_COLLISION_EN
        , .playfield(1'b0), .collision(coll_c)
`endif
    );

`ifndef SPRITE_COLLISION_EN
    assign coll_a = 1'b0;
    assign coll_b = 1'b0;
    assign coll_c = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int sel = 0;
    bit exp_q[$];

    logic obs_gfx, obs_busy;
    int   obs_addr;
    always_comb begin
        obs_gfx  = gfx_a;
        obs_busy = busy_a;
        obs_addr = int'(addr_a);
        case (sel)
            1: begin obs_gfx = gfx_b; obs_busy = busy_b; obs_addr = int'(addr_b); end
            2: begin obs_gfx = gfx_c; obs_busy = busy_c; obs_addr = int'(addr_c); end
            default: ;
        endcase
    end

    function automatic int width_of(input int d);
        return (d == 2) ? 32 : 16;
    endfunction

    function automatic int scale_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic logic [7:0] rom_byte(input int d, input int idx);
        return (d == 2) ? rom32[idx] : rom16[idx];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic start_sprite(input bit hm, input bit vm);
        hmirror = hm;
        vmirror = vm;
        vstart  = 1'b1;
        cyc();
        vstart  = 1'b0;
        hmirror = 1'b0;
        vmirror = 1'b0;
        checks++;
        if (obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_vstart got=%b exp=1", obs_busy);
        end
    endtask

    // One row: load, fetch with rom_addr checks, hstart, then scoreboarded draw.
    task automatic run_row(input int d, input int y, input bit hm, input bit vm,
                           input bit vs_mid, input int pf_at, input int abort_at);
        int w, nb, s, row, nclk, p, col, ea;
        logic [7:0] bt;
        bit e;
        w   = width_of(d);
        nb  = w / 8;
        s   = scale_of(d);
        row = vm ? (H - 1 - y) : y;
        load = 1'b1;
        cyc();
        load = 1'b0;
        for (int b = 0; b < nb; b++) begin
            cyc();
            ea = row * nb + b;
            checks++;
            if (obs_addr !== ea) begin
                errors++;
                $display("FAIL rom_addr d=%0d row=%0d byte=%0d got=%0d exp=%0d", d, y, b, obs_addr, ea);
            end
            if (vs_mid && b == 0) begin
                vstart  = 1'b1;
                hmirror = ~hm;
                vmirror = ~vm;
                hstart  = 1'b1;
            end
            cyc();
            vstart  = 1'b0;
            hmirror = 1'b0;
            vmirror = 1'b0;
            hstart  = 1'b0;
        end
        hstart = 1'b1;
        cyc();
        hstart = 1'b0;
        nclk = w << s;
        for (int k = 0; k < nclk; k++) begin
            p   = k >> s;
            col = hm ? (w - 1 - p) : p;
            bt  = rom_byte(d, row * nb + col / 8);
            exp_q.push_back(bt[col % 8]);
        end
        exp_q.push_back(1'b0);
        for (int k = 0; k <= nclk; k++) begin
            if (k == abort_at) begin
                exp_q.delete();
                return;
            end
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (obs_gfx !== e) begin
                errors++;
                $display("FAIL gfx d=%0d row=%0d clk=%0d got=%b exp=%b", d, y, k, obs_gfx, e);
            end
            if (k == 0) begin
                checks++;
                if (obs_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_draw d=%0d row=%0d got=%b exp=1", d, y, obs_busy);
                end
            end
            playfield = (k == pf_at);
        end
        playfield = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            checks++;
            if (obs_gfx !== 1'b0 || obs_busy !== 1'b0 || obs_addr !== 0) begin
                errors++;
                $display("FAIL reset_state d=%0d gfx=%b busy=%b addr=%0d exp=0/0/0", d, obs_gfx, obs_busy, obs_addr);
            end
        end
        checks++;
        if (coll_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_collision got=%b exp=0", coll_a);
        end
    endtask

    task automatic test_basic();
        sel = 0;
        do_reset();
        rom16[0] = 8'h01;
        rom16[1] = 8'h80;
        start_sprite(1'b0, 1'b0);
        run_row(0, 0, 1'b0, 1'b0, 1'b0, -1, -1);
        run_row(0, 1, 1'b0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_mirror();
        sel = 0;
        do_reset();
        start_sprite(1'b1, 1'b0);
        run_row(0, 0, 1'b1, 1'b0, 1'b0, -1, -1);
        do_reset();
        rom16[0] = 8'h03;
        rom16[1] = 8'h00;
        start_sprite(1'b1, 1'b0);
        run_row(0, 0, 1'b1, 1'b0, 1'b0, -1, -1);
        do_reset();
        start_sprite(1'b0, 1'b1);
        run_row(0, 0, 1'b0, 1'b1, 1'b0, -1, -1);
        run_row(0, 1, 1'b0, 1'b1, 1'b0, -1, -1);
        do_reset();
        start_sprite(1'b1, 1'b1);
        run_row(0, 0, 1'b1, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_scale();
        sel = 1;
        do_reset();
        rom16[0] = 8'h01;
        rom16[1] = 8'h00;
        start_sprite(1'b0, 1'b0);
        run_row(1, 0, 1'b0, 1'b0, 1'b0, -1, -1);
        run_row(1, 1, 1'b0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_wide_frame();
        sel = 2;
        do_reset();
        start_sprite(1'b1, 1'b0);
        for (int y = 0; y < H; y++)
            run_row(2, y, 1'b1, 1'b0, (y == 5), -1, -1);
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_end_frame got=%b exp=0", obs_busy);
        end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        do_reset();
        start_sprite(1'b0, 1'b0);
        for (int y = 0; y < 7; y++)
            run_row(0, y, 1'b0, 1'b0, (y == 3), -1, -1);
        run_row(0, 7, 1'b0, 1'b0, 1'b0, -1, 5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (obs_gfx !== 1'b0 || obs_busy !== 1'b0 || obs_addr !== 0) begin
            errors++;
            $display("FAIL reset_mid gfx=%b busy=%b addr=%0d exp=0/0/0", obs_gfx, obs_busy, obs_addr);
        end
    endtask

`ifdef SPRITE_COLLISION_EN
    task automatic test_collision();
        sel = 0;
        do_reset();
        rom16[4] = 8'h08;
        start_sprite(1'b0, 1'b0);
        run_row(0, 0, 1'b0, 1'b0, 1'b0, -1, -1);
        run_row(0, 1, 1'b0, 1'b0, 1'b0, -1, -1);
        checks++;
        if (coll_a !== 1'b0) begin
            errors++;
            $display("FAIL collision_before got=%b exp=0", coll_a);
        end
        run_row(0, 2, 1'b0, 1'b0, 1'b0, 3, -1);
        checks++;
        if (coll_a !== 1'b1) begin
            errors++;
            $display("FAIL collision_hit got=%b exp=1", coll_a);
        end
        for (int y = 3; y < H; y++)
            run_row(0, y, 1'b0, 1'b0, 1'b0, -1, -1);
        checks++;
        if (coll_a !== 1'b1) begin
            errors++;
            $display("FAIL collision_sticky got=%b exp=1", coll_a);
        end
        vstart = 1'b1;
        cyc();
        vstart = 1'b0;
        checks++;
        if (coll_a !== 1'b0) begin
            errors++;
            $display("FAIL collision_clear got=%b exp=0", coll_a);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; vstart = 1'b0; load = 1'b0; hstart = 1'b0;
        hmirror = 1'b0; vmirror = 1'b0; playfield = 1'b0;
        for (int i = 0; i < 32; i++) rom16[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 64; i++) rom32[i] = 8'($urandom_range(0, 255));
        test_reset();
        test_basic();
        test_mirror();
        test_scale();
        test_wide_frame();
        test_reset_mid();
`ifdef SPRITE_COLLISION_EN
        test_collision();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
